context_state_store: RTL

CONTEXT_STATE_STORE -- requirements
Module: context_state_store

---
 rtl/context_state_store_if.sv | 28 ++
 rtl/context_state_store.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/context_state_store_if.sv
// Handshake and statistics bus between the context-mapping stage and the
// context state store.
interface context_state_store_if #(
  parameter int mappedQ_length = 9,
  parameter int ERR_WIDTH      = 9
);
  logic                        ctx_valid;
  logic                        ctx_ready;
  logic [mappedQ_length-1:0]   C_t;
  logic                        stat_valid;
  logic [15:0]                 A_q;
  logic signed [15:0]          B_q;
  logic signed [7:0]           C_q;
  logic [6:0]                  N_q;
  logic                        err_valid;
  logic signed [ERR_WIDTH-1:0] Errval;
  logic                        ctx_err;

  modport master (
    output ctx_valid, C_t, err_valid, Errval,
    input  ctx_ready, stat_valid, A_q, B_q, C_q, N_q, ctx_err
  );

  modport slave (
    input  ctx_valid, C_t, err_valid, Errval,
    output ctx_ready, stat_valid, A_q, B_q, C_q, N_q, ctx_err
  );
endinterface

// File: rtl/context_state_store.sv
// Per-context A/B/C/N statistics store with read-modify-write update and
// bias correction for regular-mode context modelling.
module context_state_store #(
    parameter int mappedQ_length = 9,
    parameter int CONTEXTS       = 365,
    parameter int ERR_WIDTH      = 9,
    parameter int A_INIT         = 4,
    parameter int RESET_T        = 64,
    parameter int NEAR           = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    context_state_store_if.slave bus
);

    localparam int AW = mappedQ_length;
    localparam int W  = 18;
    localparam logic [AW-1:0]        LAST    = AW'(CONTEXTS - 1);
    localparam logic [6:0]           RESET_N = 7'(RESET_T);
    localparam logic signed [W-1:0]  QMULT   = W'(2 * NEAR + 1);
    localparam logic signed [W-1:0]  ZERO    = W'(0);
    localparam logic signed [W-1:0]  ONE     = W'(1);
    localparam logic signed [7:0]    C_MIN   = -8'sd128;
    localparam logic signed [7:0]    C_MAX   = 8'sd127;

    typedef enum logic [2:0] {INIT, IDLE, READ, RESP, WRITE} state_t;

    state_t                      state;
    logic [AW-1:0]               init_addr;
    logic [AW-1:0]               addr_r;
    logic signed [ERR_WIDTH-1:0] err_r;

    logic [15:0]        mem_a [CONTEXTS];
    logic signed [15:0] mem_b [CONTEXTS];
    logic signed [7:0]  mem_c [CONTEXTS];
    logic [6:0]         mem_n [CONTEXTS];

    logic                 mem_we;
    logic [AW-1:0]        wr_addr;
    logic [15:0]          wr_a;
    logic signed [15:0]   wr_b;
    logic signed [7:0]    wr_c;
    logic [6:0]           wr_n;
    logic signed [W-1:0]  err_x, a_n, b_n, c_n, n_n;

    // Update works from the held response outputs, which still carry the read values.
    always_comb begin
        err_x = W'(err_r);
        a_n   = W'(bus.A_q);
        b_n   = W'(bus.B_q);
        c_n   = W'(bus.C_q);
        n_n   = W'(bus.N_q);
        b_n   = b_n + err_x * QMULT;
        a_n   = a_n + ((err_x < ZERO) ? -err_x : err_x);
        if (bus.N_q == RESET_N) begin
            a_n = a_n >>> 1;
            b_n = b_n >>> 1;
            n_n = n_n >>> 1;
        end
        n_n = n_n + ONE;
        if (b_n <= -n_n) begin
            b_n = b_n + n_n;
            if (bus.C_q != C_MIN) c_n = c_n - ONE;
            if (b_n <= -n_n) b_n = ONE - n_n;
        end else if (b_n > ZERO) begin
            b_n = b_n - n_n;
            if (bus.C_q != C_MAX) c_n = c_n + ONE;
            if (b_n > ZERO) b_n = ZERO;
        end
    end

    always_comb begin
        mem_we  = reset_n && (state == INIT || state == WRITE);
        wr_addr = addr_r;
        wr_a    = 16'(a_n);
        wr_b    = 16'(b_n);
        wr_c    = 8'(c_n);
        wr_n    = 7'(n_n);
        if (state == INIT) begin
            wr_addr = init_addr;
            wr_a    = 16'(A_INIT);
            wr_b    = '0;
            wr_c    = '0;
            wr_n    = 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
            mem_c[wr_addr] <= wr_c;
            mem_n[wr_addr] <= wr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= INIT;
            init_addr      <= '0;
            addr_r         <= '0;
            err_r          <= '0;
            bus.ctx_ready  <= 1'b0;
            bus.stat_valid <= 1'b0;
            bus.ctx_err    <= 1'b0;
            bus.A_q        <= '0;
            bus.B_q        <= '0;
            bus.C_q        <= '0;
            bus.N_q        <= '0;
        end else begin
            bus.ctx_err <= 1'b0;
            case (state)
                INIT: begin
                    if (init_addr == LAST) begin
                        state         <= IDLE;
                        bus.ctx_ready <= 1'b1;
                    end else begin
                        init_addr <= init_addr + AW'(1);
                    end
                end
                IDLE: begin
                    if (bus.ctx_valid && bus.ctx_ready) begin
                        if (bus.C_t <= LAST) begin
                            addr_r        <= bus.C_t;
                            bus.ctx_ready <= 1'b0;
                            state         <= READ;
                        end else begin
                            bus.ctx_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    bus.A_q        <= mem_a[addr_r];
                    bus.B_q        <= mem_b[addr_r];
                    bus.C_q        <= mem_c[addr_r];
                    bus.N_q        <= mem_n[addr_r];
                    bus.stat_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.err_valid) begin
                        err_r          <= bus.Errval;
                        bus.stat_valid <= 1'b0;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    bus.ctx_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
